// File: rtl/prog_loader.sv
// Program loader: assembles a high-byte-first byte stream into 16-bit words,
// writes them to program RAM and releases the processor on the halt word.
module prog_loader #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DEPTH    = 1024,
  parameter logic [15:0] END_WORD = 16'h3c00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [7:0]        byte_in,
  input  logic              byte_vld,
  output logic              byte_rdy,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic              start,
  output logic              done,
  output logic              overflow_err,
  output logic [ADDR_W:0]   word_count,
  output logic [15:0]       checksum
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    LOAD_LO,
    WRITE,
    RUN,
    ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          hi_q, hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         din_q, din_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [15:0]         sum_q, sum_d;
  logic                hs;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Ready and strobe decode from state alone, never from byte_vld.
  assign byte_rdy     = (state_q == LOAD_HI) || (state_q == LOAD_LO);
  assign ram_write_en = (state_q == WRITE);
  assign ram_addr     = addr_q;
  assign ram_din      = din_q;
  assign start        = start_q;
  assign done         = done_q;
  assign overflow_err = ovf_q;
  assign word_count   = cnt_q;
  assign checksum     = sum_q;

  assign hs = byte_vld && byte_rdy;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    din_d   = din_q;
    start_d = start_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    // A load request wins over everything, including a pending handshake.
    if (load_req) begin
      state_d = LOAD_HI;
      hi_d    = 8'h00;
      addr_d  = '0;
      cnt_d   = '0;
      sum_d   = 16'h0000;
      start_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        LOAD_HI: begin
          if (hs) begin
            hi_d    = byte_in;
            state_d = LOAD_LO;
          end
        end
        LOAD_LO: begin
          if (hs) begin
            din_d   = {hi_q, byte_in};
            state_d = WRITE;
          end
        end
        WRITE: begin
          cnt_d = cnt_q + (ADDR_W+1)'(1);
          sum_d = sum_q + din_q;
          if (din_q == END_WORD) begin
            state_d = RUN;
            done_d  = 1'b1;
            start_d = 1'b1;
          end else if (addr_q == LAST_ADDR) begin
            state_d = ERROR;
            ovf_d   = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = LOAD_HI;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= 8'h00;
      addr_q  <= '0;
      din_q   <= 16'h0000;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      start_q <= start_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal load, throttled stream, overflow,
// abort/restart, async reset mid-word and reload from RUN.
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        load_req;
  logic [7:0]  byte_in;
  logic        byte_vld;
  logic        byte_rdy;
  logic        ram_write_en;
  logic [9:0]  ram_addr;
  logic [15:0] ram_din;
  logic        start;
  logic        done;
  logic        overflow_err;
  logic [10:0] word_count;
  logic [15:0] checksum;

  int n_chk;
  int n_fail;
  int wr_cnt;
  int done_cnt;
  int viol;

  logic [15:0] mem [0:1023];
  logic [9:0]  log_a [4];
  logic [15:0] log_d [4];

  prog_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_req     (load_req),
    .byte_in      (byte_in),
    .byte_vld     (byte_vld),
    .byte_rdy     (byte_rdy),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .start        (start),
    .done         (done),
    .overflow_err (overflow_err),
    .word_count   (word_count),
    .checksum     (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model plus write/done logging.
  always @(posedge clk) begin
    if (ram_write_en) begin
      mem[ram_addr] = ram_din;
      if (wr_cnt < 4) begin
        log_a[wr_cnt] = ram_addr;
        log_d[wr_cnt] = ram_din;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  always @(negedge clk) begin
    if (byte_rdy && (ram_write_en || start)) viol = viol + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    @(negedge clk);
    if (gap) begin
      byte_vld = 1'b0;
      @(negedge clk);
    end
    byte_in  = b;
    byte_vld = 1'b1;
    while (!byte_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_chk++;
      n_fail++;
      $error("FAIL byte_timeout observed=%0d expected=<40", n);
    end
    @(posedge clk);
    #1;
    byte_vld = 1'b0;
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send4(input logic [31:0] w, input bit gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    viol     = 0;
    load_req = 1'b0;
    byte_in  = 8'h00;
    byte_vld = 1'b0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", 64'({byte_rdy, ram_write_en, ram_addr, ram_din,
        start, done, overflow_err, word_count, checksum}), 64'h0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);
    chk("idle_rdy", 64'(byte_rdy), 64'h0);

    // Basic load, byte_vld always high.
    wr_cnt   = 0;
    done_cnt = 0;
    pulse_load();
    send4(32'h12343c00, 1'b0);
    wait_cycles(3);
    chk("t1_mem0", 64'(mem[0]), 64'h1234);
    chk("t1_mem1", 64'(mem[1]), 64'h3c00);
    chk("t1_first_addr", 64'(log_a[0]), 64'h0);
    chk("t1_wcount", 64'(word_count), 64'h2);
    chk("t1_csum", 64'(checksum), 64'h4e34);
    chk("t1_wr", 64'(wr_cnt), 64'h2);
    wait_cycles(5);
    chk("t1_done_once", 64'(done_cnt), 64'h1);
    chk("t1_start", 64'(start), 64'h1);
    chk("t1_rdy_run", 64'(byte_rdy), 64'h0);

    // Reload from RUN: start drops at the edge that sees load_req.
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_start_drop", 64'(start), 64'h0);
    chk("t6_cnt_clear", 64'(word_count), 64'h0);
    @(negedge clk);
    load_req = 1'b0;

    // Same stream with byte_vld toggling.
    wr_cnt   = 0;
    done_cnt = 0;
    viol     = 0;
    send4(32'h12343c00, 1'b1);
    wait_cycles(4);
    chk("t2_log_a0", 64'(log_a[0]), 64'h0);
    chk("t2_log_d0", 64'(log_d[0]), 64'h1234);
    chk("t2_log_a1", 64'(log_a[1]), 64'h1);
    chk("t2_log_d1", 64'(log_d[1]), 64'h3c00);
    chk("t2_wcount", 64'(word_count), 64'h2);
    chk("t2_csum", 64'(checksum), 64'h4e34);
    chk("t2_done", 64'(done_cnt), 64'h1);
    chk("t2_start", 64'(start), 64'h1);
    chk("t2_rdy_viol", 64'(viol), 64'h0);

    // Fill all 1024 words with 0001, no halt word.
    wr_cnt   = 0;
    done_cnt = 0;
    pulse_load();
    for (int i = 0; i < 1024; i++) begin
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
    end
    wait_cycles(3);
    chk("t3_mem1023", 64'(mem[1023]), 64'h0001);
    chk("t3_ovf", 64'(overflow_err), 64'h1);
    chk("t3_start", 64'(start), 64'h0);
    chk("t3_wcount", 64'(word_count), 64'h400);
    chk("t3_csum", 64'(checksum), 64'h0400);
    chk("t3_wr", 64'(wr_cnt), 64'd1024);
    chk("t3_done", 64'(done_cnt), 64'h0);
    chk("t3_rdy_err", 64'(byte_rdy), 64'h0);
    pulse_load();
    chk("t3_ovf_clear", 64'(overflow_err), 64'h0);

    // Abort after third byte, then halt word at address 0.
    wr_cnt   = 0;
    done_cnt = 0;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    pulse_load();
    send_byte(8'h3c, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_cycles(3);
    chk("t4_mem0", 64'(mem[0]), 64'h3c00);
    chk("t4_mem1", 64'(mem[1]), 64'h0001);
    chk("t4_log_d0", 64'(log_d[0]), 64'h1122);
    chk("t4_log_a1", 64'(log_a[1]), 64'h0);
    chk("t4_wr", 64'(wr_cnt), 64'h2);
    chk("t4_wcount", 64'(word_count), 64'h1);
    chk("t4_csum", 64'(checksum), 64'h3c00);
    chk("t4_start", 64'(start), 64'h1);

    // Async reset while waiting for a low byte.
    pulse_load();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    chk("t5_pre_wcount", 64'(word_count), 64'h1);
    chk("t5_pre_rdy", 64'(byte_rdy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_reset_outputs", 64'({byte_rdy, ram_write_en, ram_addr, ram_din,
        start, done, overflow_err, word_count, checksum}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    pulse_load();
    send_byte(8'h3c, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_cycles(3);
    chk("t5_mem0", 64'(mem[0]), 64'h3c00);
    chk("t5_wcount", 64'(word_count), 64'h1);
    chk("t5_start", 64'(start), 64'h1);
    chk("t5_done", 64'(done_cnt), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
